// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared instruction field layout, opcodes, sizes and fetch states.
package instr_fetch_unit_pkg;
  localparam int IFU_DEPTH = 16;
  localparam int IFU_AW = 4;
  localparam logic [7:0] IFU_HALT = 8'h00;
  localparam int MODE_BIT = 7;
  localparam int OP_HI = 6;
  localparam int OP_LO = 4;
  localparam int RA_HI = 3;
  localparam int RA_LO = 2;
  localparam int RB_HI = 1;
  localparam int RB_LO = 0;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_INC = 3'b011;
  typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
  function automatic logic [2:0] opcode_of(input logic [7:0] b);
    return b[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_skid_fifo: 2-entry shift buffer; head is always slot 0, flush empties it.
module fetch_skid_fifo #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);
  logic [W-1:0] r_q0, r_q1;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic [1:0]   w_left;
  assign w_pop   = i_pop && o_valid;
  assign w_left  = r_cnt - {1'b0, w_pop};
  assign o_data  = r_q0;
  assign o_valid = r_cnt != 2'd0;
  assign o_full  = r_cnt == 2'd2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= '0;
    end else begin
      r_q0  <= (w_pop && r_cnt == 2'd2) ? r_q1 : (i_push && w_left == 2'd0) ? i_data : r_q0;
      r_q1  <= (i_push && w_left == 2'd1) ? i_data : r_q1;
      r_cnt <= i_flush ? 2'd0 : w_left + {1'b0, i_push};
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program memory, loader and PC; streams instruction bytes to the
// control unit through a 2-entry buffer so memory reads never wait on the F/D/E/W cadence.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int         DEPTH     = IFU_DEPTH,
  parameter int         AW        = IFU_AW,
  parameter logic [7:0] HALT_CODE = IFU_HALT
) (
  input  logic          clock_pulse,
  input  logic          resetn,
  input  logic          load_en,
  input  logic          load_we,
  input  logic [7:0]    load_data,
  input  logic          start,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [7:0]    ir_data,
  output logic [AW-1:0] ir_pc,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] load_addr,
  output logic          halted
);
  state_t        r_state, w_next;
  logic [AW-1:0] r_pc, r_la;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    w_byte;
  logic          w_is_halt, w_redir, w_start, w_fetch, w_pop, w_push, w_flush, w_full, w_loading;
  assign w_byte    = r_mem[r_pc];
  assign w_is_halt = w_byte == HALT_CODE;
  assign w_loading = r_state == S_LOAD;
  assign w_redir   = !load_en && redirect_valid && !w_loading;
  assign w_start   = !load_en && !w_redir && start && r_state != S_RUN;
  assign w_fetch   = !load_en && !w_redir && r_state == S_RUN;
  assign w_pop     = ir_valid && ir_ready;
  assign w_push    = w_fetch && !w_is_halt && (!w_full || w_pop);
  assign w_flush   = (load_en && !w_loading) || w_redir || w_start;
  assign pc_out    = r_pc;
  assign load_addr = r_la;
  always_ff @(posedge clock_pulse or negedge resetn)
    if (!resetn) r_state <= S_LOAD;
    else r_state <= w_next;
  always_comb
    w_next = load_en ? S_LOAD : (w_redir || w_start) ? S_RUN : (w_fetch && w_is_halt) ? S_HALT : r_state;
  always_comb
    halted = r_state == S_HALT;
  always_ff @(posedge clock_pulse or negedge resetn)
    if (!resetn) begin
      r_pc <= '0;
      r_la <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= HALT_CODE;
    end else begin
      r_pc <= w_redir ? redirect_pc : w_start ? '0 : w_push ? r_pc + 1'b1 : r_pc;
      r_la <= (load_en && !w_loading) ? '0 : (w_loading && load_we) ? r_la + 1'b1 : r_la;
      if (w_loading && load_we) r_mem[r_la] <= load_data;
    end
  fetch_skid_fifo #(.W(8 + AW)) u_buf (
    .clk    (clock_pulse),
    .rst_n  (resetn),
    .i_flush(w_flush),
    .i_push (w_push),
    .i_pop  (ir_ready),
    .i_data ({r_pc, w_byte}),
    .o_data ({ir_pc, ir_data}),
    .o_valid(ir_valid),
    .o_full (w_full)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_instr_fetch_unit;
  logic       clock_pulse = 1'b0;
  logic       resetn = 1'b0;
  logic       load_en = 1'b0, load_we = 1'b0, start = 1'b0, redirect_valid = 1'b0, ir_ready = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic [3:0] redirect_pc = 4'h0;
  logic       ir_valid, halted;
  logic [7:0] ir_data;
  logic [3:0] ir_pc, pc_out, load_addr;
  int checks = 0, errors = 0;
  logic [7:0]  mmem [16];
  int          mpc, mla, mmode;
  logic [11:0] mq [$];

  instr_fetch_unit dut (
    .clock_pulse(clock_pulse), .resetn(resetn), .load_en(load_en), .load_we(load_we),
    .load_data(load_data), .start(start), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
    .ir_pc(ir_pc), .pc_out(pc_out), .load_addr(load_addr), .halted(halted)
  );

  always #5 clock_pulse = ~clock_pulse;

  task automatic mreset();
    foreach (mmem[i]) mmem[i] = 8'h00;
    mpc = 0; mla = 0; mmode = 0;
    mq.delete();
  endtask

  // mode: 0 = LOAD, 1 = RUN, 2 = HALT; buffer entries are {pc, byte}
  task automatic step();
    logic [11:0] dropped;
    int prev;
    bit pop;
    @(posedge clock_pulse);
    prev = mmode;
    pop = (mq.size() != 0) && ir_ready;
    if (prev == 0 && load_we) begin mmem[mla] = load_data; mla = (mla + 1) % 16; end
    if (pop) dropped = mq.pop_front();
    if (load_en) begin
      if (prev != 0) begin mq.delete(); mla = 0; end
      mmode = 0;
    end else if (redirect_valid && prev != 0) begin
      mq.delete(); mpc = int'(redirect_pc); mmode = 1;
    end else if (start && prev != 1) begin
      mq.delete(); mpc = 0; mmode = 1;
    end else if (prev == 1) begin
      if (mmem[mpc] == 8'h00) mmode = 2;
      else if (mq.size() < 2) begin
        mq.push_back({4'(mpc), mmem[mpc]});
        mpc = (mpc + 1) % 16;
      end
    end
    @(negedge clock_pulse);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ir_valid); end
    checks++; if ({ir_data, ir_pc, pc_out, load_addr} !== 20'h0) begin errors++; $display("FAIL reset_regs got %h want 0", {ir_data, ir_pc, pc_out, load_addr}); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    @(negedge clock_pulse);
    resetn = 1'b1;
    mreset();
  endtask

  task automatic test_load();
    logic [7:0] prog [3] = '{8'h1D, 8'h31, 8'h00};
    load_en = 1'b1;
    for (int i = 0; i < 3; i++) begin load_we = 1'b1; load_data = prog[i]; step(); end
    load_we = 1'b0; load_en = 1'b0;
    step();
    checks++; if (load_addr !== 4'd3) begin errors++; $display("FAIL load_addr got %0d want 3", load_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL load_no_fetch got %b want 0", ir_valid); end
  endtask

  task automatic test_run();
    ir_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL run_lat1 got %b want 0", ir_valid); end
    step();
    checks++; if ({ir_valid, ir_data, ir_pc} !== {1'b1, 8'h1D, 4'd0}) begin errors++; $display("FAIL run_first got %b/%h/%0d want 1/1d/0", ir_valid, ir_data, ir_pc); end
    step();
    checks++; if ({ir_valid, ir_data, ir_pc} !== {1'b1, 8'h31, 4'd1}) begin errors++; $display("FAIL run_second got %b/%h/%0d want 1/31/1", ir_valid, ir_data, ir_pc); end
    step();
    checks++; if ({ir_valid, halted, pc_out} !== {1'b0, 1'b1, 4'd2}) begin errors++; $display("FAIL run_halt got v%b h%b pc%0d want v0 h1 pc2", ir_valid, halted, pc_out); end
  endtask

  task automatic test_stall();
    ir_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++; if ({ir_valid, ir_data, ir_pc, pc_out} !== {1'b1, 8'h1D, 4'd0, 4'd2}) begin errors++; $display("FAIL stall_hold got %b/%h/%0d pc%0d want 1/1d/0 pc2", ir_valid, ir_data, ir_pc, pc_out); end
    step();
    checks++; if ({ir_data, ir_pc} !== {8'h1D, 4'd0}) begin errors++; $display("FAIL stall_stable got %h/%0d want 1d/0", ir_data, ir_pc); end
    ir_ready = 1'b1;
    step();
    checks++; if ({ir_valid, ir_data, ir_pc} !== {1'b1, 8'h31, 4'd1}) begin errors++; $display("FAIL stall_drain got %b/%h/%0d want 1/31/1", ir_valid, ir_data, ir_pc); end
    step();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b want 0", ir_valid); end
  endtask

  task automatic test_wrap();
    int got = 0;
    load_en = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin load_we = 1'b1; load_data = 8'h10 + 8'(i); step(); end
    load_we = 1'b0; load_en = 1'b0;
    checks++; if (load_addr !== 4'd0) begin errors++; $display("FAIL wrap_load_addr got %0d want 0", load_addr); end
    ir_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40 && got < 17; c++) begin
      step();
      if (ir_valid) begin
        checks++;
        if ({ir_data, ir_pc} !== {8'h10 + 8'(got % 16), 4'(got % 16)}) begin errors++; $display("FAIL wrap_seq%0d got %h/%0d want %h/%0d", got, ir_data, ir_pc, 8'h10 + 8'(got % 16), got % 16); end
        got++;
      end
    end
    checks++; if (got != 17) begin errors++; $display("FAIL wrap_count got %0d want 17", got); end
  endtask

  task automatic test_redirect();
    ir_ready = 1'b0;
    repeat (3) step();
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL redir_full got %b want 1", ir_valid); end
    redirect_valid = 1'b1; redirect_pc = 4'd5;
    step();
    redirect_valid = 1'b0;
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", ir_valid); end
    step();
    checks++; if ({ir_valid, ir_data, ir_pc} !== {1'b1, 8'h15, 4'd5}) begin errors++; $display("FAIL redir_target got %b/%h/%0d want 1/15/5", ir_valid, ir_data, ir_pc); end
    ir_ready = 1'b1;
    step();
    checks++; if ({ir_data, ir_pc} !== {8'h16, 4'd6}) begin errors++; $display("FAIL redir_next got %h/%0d want 16/6", ir_data, ir_pc); end
  endtask

  task automatic test_random();
    load_en = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1;
      load_data = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      step();
    end
    load_we = 1'b0; load_en = 1'b0;
    for (int c = 0; c < 600; c++) begin
      load_en = ($urandom_range(0, 99) == 0);
      load_we = $urandom_range(0, 1) == 1;
      load_data = 8'($urandom_range(0, 255));
      start = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_pc = 4'($urandom_range(0, 15));
      ir_ready = ($urandom_range(0, 2) != 0);
      step();
      checks++;
      if (ir_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d got %b want %b", c, ir_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++;
        if ({ir_pc, ir_data} !== mq[0]) begin errors++; $display("FAIL rnd_head c%0d got %h want %h", c, {ir_pc, ir_data}, mq[0]); end
      end
      checks++;
      if ({pc_out, load_addr, halted} !== {4'(mpc), 4'(mla), mmode == 2}) begin errors++; $display("FAIL rnd_state c%0d got pc%0d la%0d h%b want pc%0d la%0d h%b", c, pc_out, load_addr, halted, mpc, mla, mmode == 2); end
    end
    {load_en, load_we, start, redirect_valid} = 4'b0;
  endtask

  task automatic test_midreset();
    load_en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin load_we = 1'b1; load_data = 8'h41 + 8'(i); step(); end
    load_we = 1'b0; load_en = 1'b0; ir_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 resetn = 1'b0;
    #1;
    checks++; if ({ir_valid, halted, ir_data, ir_pc, pc_out, load_addr} !== 22'h0) begin errors++; $display("FAIL midreset got %h want 0", {ir_valid, halted, ir_data, ir_pc, pc_out, load_addr}); end
    @(negedge clock_pulse);
    resetn = 1'b1;
    mreset();
    start = 1'b1; ir_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++; if ({halted, ir_valid} !== 2'b10) begin errors++; $display("FAIL midreset_mem got h%b v%b want h1 v0", halted, ir_valid); end
  endtask

  initial begin
    mreset();
    test_reset();
    test_load();
    test_run();
    test_stall();
    test_wrap();
    test_redirect();
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
